seq_ones_alu: RTL and testbench

- Parametrised, multi-cycle ones'-complement ALU for the datapath; successor to the single-cycle combinational ALU.
- Adds width generalisation, an iterative shift-add multiplier and restoring divider, a start/busy/done handshake, and status flags (overflow, divide-by-zero, bad command).
- Sits between the register file and the accumulator write-back, which samples results on done.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/ones_comp_adder.sv | 22 ++
 rtl/seq_ones_alu.sv | 194 +++++++++++++++++++
 tb/tb_seq_ones_alu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ones'-complement ALU.
// Holds the command encodings, the controller state type and helpers for
// ones'-complement magnitude and negation. The helpers work on a 32-bit
// container so that any legal word width (4..32) can use them.
package alu_pkg;

  localparam logic [2:0] CMD_ADD = 3'd0;
  localparam logic [2:0] CMD_SUB = 3'd1;
  localparam logic [2:0] CMD_AND = 3'd2;
  localparam logic [2:0] CMD_MUL = 3'd3;
  localparam logic [2:0] CMD_DIV = 3'd4;

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  // Magnitude of a w-bit ones'-complement word; -0 maps to 0.
  function automatic logic [31:0] oc_mag(input logic [31:0] x, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] sh;
    mask = (32'd1 << (w - 1)) - 32'd1;
    sh   = x >> (w - 1);
    return sh[0] ? (~x & mask) : (x & mask);
  endfunction

  // Ones'-complement negation of a w-bit word (bits above w are cleared).
  function automatic logic [31:0] oc_neg(input logic [31:0] x, input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;  // shift by 32 yields 0, so mask is all ones
    return ~x & mask;
  endfunction

endpackage

// File: rtl/ones_comp_adder.sv
// Ones'-complement adder with end-around carry.
// Ports:
//   x, y  in  WIDTH  addends (ones'-complement)
//   sum   out WIDTH  x + y, carry-out folded back into bit 0
//   ovf   out 1      addend signs equal and result sign differs
module ones_comp_adder #(
  parameter int unsigned WIDTH = 15
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0] raw;

  assign raw = {1'b0, x} + {1'b0, y};
  // A -0 result is left as produced; the folded carry cannot ripple out again.
  assign sum = raw[WIDTH-1:0] + {{(WIDTH - 1){1'b0}}, raw[WIDTH]};
  assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/seq_ones_alu.sv
// Multi-cycle ones'-complement ALU with start/busy/done handshake.
// ADD/SUB/AND/illegal complete in one cycle; MUL (shift-add) and DIV
// (restoring) iterate over magnitudes for MAG_W cycles, then fix signs.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   start, cmd     request and operation, accepted while busy = 0
//   a, b           operands, captured at acceptance
//   busy, done     iteration in progress / one-cycle completion pulse
//   res, res_aux   result / MUL low word or DIV remainder
//   ovf, div_zero, bad_cmd  status flags of the last completed operation
module seq_ones_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        cmd,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic [DATA_W-1:0] res_aux,
  output logic              ovf,
  output logic              div_zero,
  output logic              bad_cmd
);

  localparam int unsigned MAG_W = DATA_W - 1;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         cmd_q, cmd_d;
  logic               sign_q, sign_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [MAG_W-1:0]   hi_q, hi_d;   // MUL high partial product / DIV remainder
  logic [MAG_W-1:0]   lo_q, lo_d;   // MUL multiplier->low word / DIV dividend->quotient
  logic [MAG_W-1:0]   dv_q, dv_d;   // multiplicand or divisor magnitude
  logic [DATA_W-1:0]  res_q, res_d, aux_q, aux_d;
  logic               ovf_q, ovf_d, dz_q, dz_d, bad_q, bad_d, done_q, done_d;

  logic [DATA_W-1:0]  add_y, add_sum;
  logic               add_ovf;
  logic [MAG_W:0]     mul_sum, div_shift;
  logic [MAG_W-1:0]   q_mag;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [MAG_W-1:0] m, input logic neg);
    return neg ? DATA_W'(oc_neg(32'({1'b0, m}), DATA_W)) : {1'b0, m};
  endfunction

  assign add_y = (cmd == CMD_SUB) ? ~b : b;

  ones_comp_adder #(
    .WIDTH(DATA_W)
  ) u_add (
    .x  (a),
    .y  (add_y),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    sign_d  = sign_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dv_d    = dv_q;
    res_d   = res_q;
    aux_d   = aux_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    bad_d   = bad_q;
    done_d  = 1'b0;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    div_shift = {hi_q, lo_q[MAG_W-1]};
    // Divide-by-zero naturally yields all-ones, forced anyway for clarity.
    q_mag     = (dv_q == '0) ? '1 : lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd == CMD_MUL || cmd == CMD_DIV) begin
            state_d = ITER;
            cnt_d   = '0;
            cmd_d   = cmd;
            sign_d  = a[DATA_W-1] ^ b[DATA_W-1];
            a_d     = a;
            hi_d    = '0;
            lo_d    = MAG_W'(oc_mag(32'(a), DATA_W));
            dv_d    = MAG_W'(oc_mag(32'(b), DATA_W));
          end else begin
            done_d = 1'b1;
            aux_d  = '0;
            ovf_d  = 1'b0;
            dz_d   = 1'b0;
            bad_d  = 1'b0;
            case (cmd)
              CMD_ADD, CMD_SUB: begin
                res_d = add_sum;
                ovf_d = add_ovf;
              end
              CMD_AND: res_d = a & b;
              default: begin
                res_d = '0;
                bad_d = 1'b1;
              end
            endcase
          end
        end
      end
      ITER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cmd_q == CMD_MUL) begin
          hi_d = mul_sum[MAG_W:1];
          lo_d = {mul_sum[0], lo_q[MAG_W-1:1]};
        end else if (div_shift >= {1'b0, dv_q}) begin
          // Difference is below the divisor, so MAG_W bits suffice.
          hi_d = div_shift[MAG_W-1:0] - dv_q;
          lo_d = {lo_q[MAG_W-2:0], 1'b1};
        end else begin
          hi_d = div_shift[MAG_W-1:0];
          lo_d = {lo_q[MAG_W-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(MAG_W - 1)) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        bad_d   = 1'b0;
        if (cmd_q == CMD_MUL) begin
          dz_d  = 1'b0;
          res_d = cond_neg(hi_q, sign_q);
          aux_d = cond_neg(lo_q, sign_q);
        end else begin
          dz_d  = (dv_q == '0);
          res_d = cond_neg(q_mag, sign_q);
          aux_d = (dv_q == '0) ? a_q : cond_neg(hi_q, a_q[DATA_W-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      sign_q  <= 1'b0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dv_q    <= '0;
      res_q   <= '0;
      aux_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      sign_q  <= sign_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dv_q    <= dv_d;
      res_q   <= res_d;
      aux_q   <= aux_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      bad_q   <= bad_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign res      = res_q;
  assign res_aux  = aux_q;
  assign ovf      = ovf_q;
  assign div_zero = dz_q;
  assign bad_cmd  = bad_q;

endmodule

// File: tb/tb_seq_ones_alu.sv
// Directed bench for seq_ones_alu at DATA_W = 15.
module tb_seq_ones_alu;

  localparam int unsigned DW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    cmd = 3'd0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          busy, done, ovf, div_zero, bad_cmd;
  logic [DW-1:0] res, res_aux;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]    cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic [DW-1:0] aux;
    logic          ovf;
    logic          dz;
    logic          bad;
    int            lat;
  } vec_t;

  vec_t vecs[14];

  seq_ones_alu #(
    .DATA_W(DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cmd     (cmd),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .res     (res),
    .res_aux (res_aux),
    .ovf     (ovf),
    .div_zero(div_zero),
    .bad_cmd (bad_cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a request, return #1 after the accept edge with inputs scrambled.
  task automatic issue(input logic [2:0] c, input logic [DW-1:0] x, input logic [DW-1:0] y);
    @(negedge clk);
    cmd   = c;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cmd   = 3'd2;
    a     = 15'h2AAA;
    b     = 15'h5555;
  endtask

  // Latency counts the accept edge as 1; bounded so a dead DUT still ends.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " res"}, 32'(res), 32'd0);
    check({tag, " res_aux"}, 32'(res_aux), 32'd0);
    check({tag, " flags"}, {29'd0, ovf, div_zero, bad_cmd}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;

    //            cmd  a         b         res       aux       ovf   dz    bad   lat
    vecs[0]  = '{3'd0, 15'h0005, 15'h7FFA, 15'h7FFF, 15'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{3'd0, 15'h7FFE, 15'h0003, 15'h0002, 15'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{3'd0, 15'h3FFF, 15'h0001, 15'h4000, 15'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd1, 15'h0003, 15'h0003, 15'h7FFF, 15'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd2, 15'h1234, 15'h0FF0, 15'h0230, 15'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd1, 15'h4000, 15'h0001, 15'h3FFF, 15'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd0, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd4, 15'h7F9B, 15'h0007, 15'h7FF1, 15'h7FFD, 1'b0, 1'b0, 1'b0, 16};
    vecs[8]  = '{3'd4, 15'h0009, 15'h7FFF, 15'h4000, 15'h0009, 1'b0, 1'b1, 1'b0, 16};
    vecs[9]  = '{3'd6, 15'h1111, 15'h2222, 15'h0000, 15'h0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{3'd3, 15'h0007, 15'h0006, 15'h0000, 15'h002A, 1'b0, 1'b0, 1'b0, 16};
    vecs[11] = '{3'd3, 15'h7FFC, 15'h7FFA, 15'h0000, 15'h000F, 1'b0, 1'b0, 1'b0, 16};
    vecs[12] = '{3'd4, 15'h0009, 15'h0000, 15'h3FFF, 15'h0009, 1'b0, 1'b1, 1'b0, 16};
    vecs[13] = '{3'd4, 15'h0000, 15'h0003, 15'h0000, 15'h0000, 1'b0, 1'b0, 1'b0, 16};

    // Reset state
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].cmd, vecs[i].a, vecs[i].b);
      if (vecs[i].lat > 1) check($sformatf("v%0d busy", i), 32'(busy), 32'd1);
      wait_done(lat);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d busy at done", i), 32'(busy), 32'd0);
      check($sformatf("v%0d res", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("v%0d res_aux", i), 32'(res_aux), 32'(vecs[i].aux));
      check($sformatf("v%0d flags", i), {29'd0, ovf, div_zero, bad_cmd},
            {29'd0, vecs[i].ovf, vecs[i].dz, vecs[i].bad});
      @(posedge clk);
      #1;
      check($sformatf("v%0d done pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d res hold", i), 32'(res), 32'(vecs[i].res));
    end

    // MUL 300 x -200 with ignored starts while busy, then back-to-back ADD.
    issue(3'd3, 15'h012C, 15'h7F37);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 3 || lat == 6) begin
        start = 1'b1;
        cmd   = 3'd0;
        a     = 15'h0001;
        b     = 15'h0001;
      end else begin
        start = 1'b0;
      end
      if (lat == 8) check("mul busy mid", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("mul latency", 32'(lat), 32'd16);
    check("mul busy at done", 32'(busy), 32'd0);
    check("mul res", 32'(res), 32'h7FFC);
    check("mul res_aux", 32'(res_aux), 32'h559F);
    check("mul flags", {29'd0, ovf, div_zero, bad_cmd}, 32'd0);
    // Still inside the done cycle: request is accepted at the next edge.
    cmd   = 3'd0;
    a     = 15'h0002;
    b     = 15'h0003;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b done", 32'(done), 32'd1);
    check("b2b res", 32'(res), 32'h0005);
    check("b2b res_aux", 32'(res_aux), 32'd0);

    // Asynchronous reset in the middle of a MUL.
    issue(3'd3, 15'h012C, 15'h7F37);
    repeat (6) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_zero("mid-reset");
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("discarded op", 32'(seen), 32'd0);
    issue(3'd0, 15'h0010, 15'h0020);
    wait_done(lat);
    check("post-reset latency", 32'(lat), 32'd1);
    check("post-reset res", 32'(res), 32'h0030);
    check("post-reset flags", {29'd0, ovf, div_zero, bad_cmd}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
